zigzag_acc: RTL

Receiving end of the zig-zag bit-plane stepping protocol. Accepts one signed partial product per beat, produced in zig-zag diagonal order for a `pw`×`pd` bit-serial multiplication. Reconstructs the full-precision result as Σ din·2^k, where k = iw+id is the diagonal index. Sits between the bit-plane popcount datapath and the output/quantizer stage, and flags any beat whose shift marker disagrees with the diagonal structure it tracks internally.

---
 rtl/zigzag_acc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/zigzag_acc.sv
// zigzag_acc: accumulates zig-zag ordered signed partial products into a full-precision result
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   clr      synchronous active-high reset, overrides every other input
//   pw, pd   weight / data precision, latched on the first beat (0 means 1)
//   in_vld   partial product valid
//   in_rdy   beat accepted this cycle when high (== !out_vld)
//   in_dat   signed partial product
//   in_sh    beat opens a new diagonal
//   out_vld  result valid, held until out_rdy
//   out_rdy  consumer takes the result
//   out_dat  signed result (zero while no result is held)
//   busy     multiplication in progress (ACC or HOLD)
//   err      sticky in_sh protocol error, cleared only by clr
module zigzag_acc #(
    parameter int BPREC = 4,
    parameter int BDIN  = 16,
    parameter int BACC  = 48
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [BPREC-1:0] pw,
    input  logic [BPREC-1:0] pd,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [BDIN-1:0]  in_dat,
    input  logic             in_sh,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [BACC-1:0]  out_dat,
    output logic             busy,
    output logic             err
);
    localparam int KW = BPREC + 1;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           st, st_n;
    logic [BPREC-1:0] pw_r, pd_r;
    logic [KW-1:0]    k, j, len;
    logic [BACC-1:0]  acc;
    logic             err_r;

    logic             take;
    logic [BPREC-1:0] pw_s, pd_s;
    logic [KW-1:0]    k_cur, j_cur, len_cur, k_last, k_adv;
    logic             diag_end, last, exp_sh;
    logic [BACC-1:0]  term;

    // L(k) = min(k+1, p, q, p+q-1-k); the last operand only wraps past the
    // final diagonal, where the result is never used.
    function automatic logic [KW-1:0] diag_len(input logic [KW-1:0] kk,
                                               input logic [BPREC-1:0] p,
                                               input logic [BPREC-1:0] q);
        logic [KW-1:0] m, r;
        m = kk + KW'(1);
        m = (KW'(p) < m) ? KW'(p) : m;
        m = (KW'(q) < m) ? KW'(q) : m;
        r = KW'(p) + KW'(q) - KW'(1) - kk;
        return (r < m) ? r : m;
    endfunction

    // k/j/len hold the position of the NEXT beat; the first beat of a
    // multiplication is always the lone beat of diagonal 0, so IDLE views
    // the position as (0,0) with length 1 regardless of the registers.
    always_comb begin
        take     = in_vld & in_rdy;
        pw_s     = (st == IDLE) ? ((pw == '0) ? BPREC'(1) : pw) : pw_r;
        pd_s     = (st == IDLE) ? ((pd == '0) ? BPREC'(1) : pd) : pd_r;
        k_cur    = (st == IDLE) ? '0 : k;
        j_cur    = (st == IDLE) ? '0 : j;
        len_cur  = (st == IDLE) ? KW'(1) : len;
        k_last   = KW'(pw_s) + KW'(pd_s) - KW'(2);
        diag_end = (j_cur == len_cur - KW'(1));
        last     = diag_end && (k_cur == k_last);
        k_adv    = k_cur + KW'(1);
        exp_sh   = (j_cur == '0) && (k_cur != '0);
        term     = {{(BACC-BDIN){in_dat[BDIN-1]}}, in_dat} << k_cur;
    end

    always_ff @(posedge clk) begin
        if (clr) st <= IDLE;
        else     st <= st_n;
    end

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    st_n = take ? (last ? HOLD : ACC) : IDLE;
            ACC:     st_n = (take && last) ? HOLD : ACC;
            HOLD:    st_n = out_rdy ? IDLE : HOLD;
            default: st_n = IDLE;
        endcase
    end

    always_comb begin
        out_vld = (st == HOLD);
        in_rdy  = !out_vld;
        busy    = (st != IDLE);
        out_dat = out_vld ? acc : '0;
        err     = err_r;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc   <= '0;
            k     <= '0;
            j     <= '0;
            len   <= '0;
            pw_r  <= BPREC'(1);
            pd_r  <= BPREC'(1);
            err_r <= 1'b0;
        end else if (take) begin
            acc   <= ((st == IDLE) ? '0 : acc) + term;
            k     <= diag_end ? k_adv : k_cur;
            j     <= diag_end ? '0 : j_cur + KW'(1);
            len   <= diag_end ? diag_len(k_adv, pw_s, pd_s) : len_cur;
            pw_r  <= pw_s;
            pd_r  <= pd_s;
            err_r <= err_r | (in_sh != exp_sh);
        end else if (st == HOLD && out_rdy) begin
            acc <= '0;
            k   <= '0;
            j   <= '0;
        end
    end
endmodule
